// File: rtl/ifetch_pkg.sv
// Shared types for the rvga pipeline: fetch FSM states, NOP encoding, word type.
package rvga_types;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DRAIN
    } ifetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to
// instruction memory, and presents a registered instr/pc/valid to decode.
// Define RVGA_IFETCH_PERF_EN to add the fetch_cnt_o / imem_wait_cnt_o counters.
module ifetch
    import rvga_types::*;
#(
    parameter int unsigned              XLEN_P     = 32,
    parameter logic [XLEN_P-1:0]        PC_RESET_P = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_v_i,
    input  logic                bubble_v_i,
    input  logic                br_v_i,
    input  logic [XLEN_P-1:0]   br_tgt_i,
    output logic                imem_read_v_o,
    output logic [XLEN_P-1:0]   imem_addr_o,
    input  logic                imem_resp_v_i,
    input  logic [XLEN_P-1:0]   imem_data_i,
    output logic                instr_v_o,
    output logic [XLEN_P-1:0]   instr_o,
    output logic [XLEN_P-1:0]   pc_o
`ifdef RVGA_IFETCH_PERF_EN
    ,
    output logic [31:0]         fetch_cnt_o,
    output logic [31:0]         imem_wait_cnt_o
`endif
);

    ifetch_state_e       state_q, state_d;
    logic [XLEN_P-1:0]   pc_q, pc_d;
    logic [XLEN_P-1:0]   req_addr_q, req_addr_d;
    logic [XLEN_P-1:0]   hold_q, hold_d;
    logic                load;
    logic [XLEN_P-1:0]   load_word;
    logic [XLEN_P-1:0]   req_addr_inc;

    assign req_addr_inc  = req_addr_q + XLEN_P'(4);
    assign imem_read_v_o = (state_q == WAIT) || (state_q == DRAIN);
    assign imem_addr_o   = req_addr_q;

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_d     = hold_q;
        load       = 1'b0;
        load_word  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (br_v_i) begin
                    pc_d = br_tgt_i;
                end else if (!bubble_v_i) begin
                    req_addr_d = pc_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (br_v_i) begin
                    pc_d    = br_tgt_i;
                    state_d = imem_resp_v_i ? IDLE : DRAIN;
                end else if (imem_resp_v_i && !stall_v_i) begin
                    load      = 1'b1;
                    load_word = imem_data_i;
                    pc_d      = req_addr_inc;
                    if (!bubble_v_i) begin
                        req_addr_d = req_addr_inc;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (imem_resp_v_i) begin
                    hold_d  = imem_data_i;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (br_v_i) begin
                    pc_d    = br_tgt_i;
                    state_d = IDLE;
                end else if (!stall_v_i) begin
                    load      = 1'b1;
                    load_word = hold_q;
                    pc_d      = req_addr_inc;
                    state_d   = IDLE;
                end
            end
            DRAIN: begin
                if (br_v_i) begin
                    pc_d = br_tgt_i;
                end
                if (imem_resp_v_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, PC, request and decode-side output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= PC_RESET_P;
            req_addr_q <= PC_RESET_P;
            hold_q     <= '0;
            instr_v_o  <= 1'b0;
            instr_o    <= XLEN_P'(NOP_INSTR);
            pc_o       <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_q     <= hold_d;
            if (br_v_i) begin
                instr_v_o <= 1'b0;
            end else if (stall_v_i) begin
                instr_v_o <= instr_v_o;
            end else if (load) begin
                instr_v_o <= 1'b1;
                instr_o   <= load_word;
                pc_o      <= req_addr_q;
            end else begin
                instr_v_o <= 1'b0;
            end
        end
    end

`ifdef RVGA_IFETCH_PERF_EN
    // Saturating delivery and memory-wait counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_o     <= '0;
            imem_wait_cnt_o <= '0;
        end else begin
            if (load && !br_v_i && !stall_v_i && (fetch_cnt_o != '1)) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if (imem_read_v_o && !imem_resp_v_i && (imem_wait_cnt_o != '1)) begin
                imem_wait_cnt_o <= imem_wait_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction-fetch stage at the head of the ifetch→decode→rfetch→execute→memory→writeback pipeline.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Reports `imem_read_v_o` to the hazard unit and obeys its `ifetch_stall_v_o` and `bubble_v_o`.
- Takes branch redirects and presents a registered instruction/PC/valid to decode.

Parameters:
- PC_RESET_P, 32'h0000_0000, PC loaded on reset.
- XLEN_P, 32, width of PC, address and instruction words.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- stall_v_i  in  1  from hazard `ifetch_stall_v_o`.
- bubble_v_i  in  1  from hazard `bubble_v_o`; branch in flight, do not fetch.
- br_v_i  in  1  resolved redirect.
- br_tgt_i  in  XLEN_P  redirect target.
- imem_read_v_o  out  1  request valid; also routed to hazard.
- imem_addr_o  out  XLEN_P  request address; held stable while `imem_read_v_o`=1.
- imem_resp_v_i  in  1  response valid.
- imem_data_i  in  XLEN_P  response instruction.
- instr_v_o  out  1  decode-side valid.
- instr_o  out  XLEN_P  instruction to decode.
- pc_o  out  XLEN_P  PC of `instr_o`.

Behaviour:
- Single clock domain. Only one request is ever outstanding.
- Registers: `pc_q` (next fetch PC), `req_addr_q` (drives `imem_addr_o`), `hold_q` (skid word), and the output registers.
- Reset values: state=IDLE, `pc_q`=PC_RESET_P, `req_addr_q`=PC_RESET_P, `instr_v_o`=0, `instr_o`=NOP_INSTR, `pc_o`=0, `imem_read_v_o`=0.
- Reset asserted mid-request abandons the request. Memory must tolerate `imem_read_v_o` dropping on reset.
- `imem_read_v_o` = (state==WAIT || state==DRAIN). It is decoded from state only, never from inputs.
- IDLE:
  - `br_v_i` → `pc_q`<=`br_tgt_i`, stay IDLE.
  - Else if `~bubble_v_i` → `req_addr_q`<=`pc_q`, go WAIT.
- WAIT:
  - `br_v_i` (with or without resp) → `pc_q`<=`br_tgt_i`. Go IDLE if resp arrives this cycle (word discarded), else go DRAIN.
  - Resp & `~stall_v_i` → outputs load {1, `imem_data_i`, `req_addr_q`}; `pc_q`<=`req_addr_q`+4 (wraps mod 2^XLEN_P). Then:
    - If `~bubble_v_i`: `req_addr_q`<=`req_addr_q`+4, stay WAIT (back-to-back fetch, one instr/cycle at zero-wait memory).
    - Else go IDLE.
  - Resp & `stall_v_i` → `hold_q`<=`imem_data_i`, go HOLD.
  - No resp → hold everything.
- HOLD (no request):
  - `br_v_i` → discard `hold_q`, `pc_q`<=`br_tgt_i`, go IDLE.
  - `~stall_v_i` → outputs load {1, `hold_q`, `req_addr_q`}; `pc_q`<=`req_addr_q`+4; go IDLE.
- DRAIN (request for a stale address still outstanding, address held):
  - On resp → discard, go IDLE.
  - `br_v_i` while draining → `pc_q`<=`br_tgt_i` (last redirect wins).
- Output register rules, in priority order:
  1. `br_v_i` → `instr_v_o`<=0.
  2. `stall_v_i` → hold all outputs.
  3. New word loaded → as above.
  4. Otherwise `instr_v_o`<=0, with `instr_o`/`pc_o` unchanged.
- `bubble_v_i` never alters the output register; it only suppresses new requests.

Optional Feature:
- RVGA_IFETCH_PERF_EN defined: adds outputs `fetch_cnt_o` [31:0] and `imem_wait_cnt_o` [31:0].
  - `fetch_cnt_o` increments per instruction delivered to the output register.
  - `imem_wait_cnt_o` increments per WAIT/DRAIN cycle without resp.
  - Both reset to 0 and saturate at all-ones.
- RVGA_IFETCH_PERF_EN undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- `rvga_types` package gets:
  - `ifetch_state_e` {IDLE, WAIT, HOLD, DRAIN}.
  - `NOP_INSTR` = 32'h0000_0013.
  - `word_t` = logic [XLEN_P-1:0].
- Single module; no sub-module is warranted.

Test Plan:
- Reset, zero-wait memory, no stalls → `imem_addr_o` 0x0, 0x4, 0x8 on consecutive cycles. `instr_v_o`=1 from the 2nd cycle after reset release, `pc_o` trailing the address by one cycle.
- Resp for 0x8 arrives while `stall_v_i`=1 for 3 cycles → state HOLD, no new request. The word appears with `pc_o`=0x8 the cycle after stall drops, then fetch resumes at 0xC.
- `br_v_i`=1, `br_tgt_i`=0x100 while waiting on 0x10 (resp 2 cycles later) → `imem_addr_o` stays 0x10 until resp, the word is discarded, the next request is 0x100, and no `instr_v_o` ever appears for 0x10.
- `bubble_v_i`=1 for 4 cycles from IDLE → `imem_read_v_o`=0 throughout. The first request follows the cycle after `bubble_v_i` falls.
- `br_v_i` and `imem_resp_v_i` in the same WAIT cycle, target 0x200 → response discarded, `instr_v_o`=0, next request 0x200.
- `rst_i` pulsed during WAIT → next cycle `imem_read_v_o`=0, `instr_v_o`=0, and the next request is PC_RESET_P.
